// File: rtl/div_exec_unit.sv
// Multi-cycle integer divider for RISC-V M DIV/DIVU/REM/REMU, broadcasting on CDB_Div.
// Fixed 34-edge latency from accept to return-to-idle.
module div_exec_unit #(
  parameter int TAG_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_div,
  input  logic [DATA_WIDTH-1:0] div_rs_data,
  input  logic [DATA_WIDTH-1:0] div_rt_data,
  input  logic [2:0]            div_func3,
  input  logic [TAG_WIDTH-1:0]  div_rd_tag,
  output logic                  div_exec_ready,
  output logic                  cdb_valid,
  output logic [TAG_WIDTH-1:0]  cdb_tag,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  cdb_branch,
  output logic                  cdb_branch_taken
);
  localparam int DW = DATA_WIDTH;
  localparam logic [5:0] LAST = 6'(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [5:0]           r_cnt;
  logic [DW-1:0]        r_quo, r_dvs, r_res;
  logic [DW:0]          r_rem;
  logic                 r_neg_q, r_neg_r, r_is_rem, r_dz;
  logic [TAG_WIDTH-1:0] r_tag;

  logic          w_accept, w_last, w_signed, w_a_neg, w_b_neg, w_fit;
  logic [DW-1:0] w_a_abs, w_b_abs, w_q, w_r, w_result;
  logic [DW:0]   w_rem_sh, w_diff;

  assign w_accept = (r_state == S_IDLE) && issue_div;
  assign w_last   = (r_state == S_BUSY) && (r_cnt == LAST);

  // func3[0]=1 selects unsigned, func3[1]=1 selects remainder; func3[2] is don't-care
  assign w_signed = ~div_func3[0];
  assign w_a_neg  = w_signed & div_rs_data[DW-1];
  assign w_b_neg  = w_signed & div_rt_data[DW-1];
  assign w_a_abs  = w_a_neg ? (~div_rs_data + 1'b1) : div_rs_data;
  assign w_b_abs  = w_b_neg ? (~div_rt_data + 1'b1) : div_rt_data;

  // One restoring step: shift next dividend bit in, subtract if it fits
  assign w_rem_sh = {r_rem[DW-1:0], r_quo[DW-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_fit    = ~w_diff[DW];

  // Divide-by-zero already yields remainder = |dividend|; only the quotient needs forcing
  assign w_q      = r_dz ? '1 : (r_neg_q ? (~r_quo + 1'b1) : r_quo);
  assign w_r      = r_neg_r ? (~r_rem[DW-1:0] + 1'b1) : r_rem[DW-1:0];
  assign w_result = r_is_rem ? w_r : w_q;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (issue_div) w_next = S_BUSY;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_res    <= '0;
      r_tag    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_dz     <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_quo    <= w_a_abs;
      r_dvs    <= w_b_abs;
      r_rem    <= '0;
      r_tag    <= div_rd_tag;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_is_rem <= div_func3[1];
      r_dz     <= (div_rt_data == '0);
    end else if (w_last) begin
      r_res <= w_result;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 6'd1;
      r_rem <= w_fit ? w_diff : w_rem_sh;
      r_quo <= {r_quo[DW-2:0], w_fit};
    end
  end

  assign div_exec_ready   = (r_state == S_IDLE);
  assign cdb_valid        = (r_state == S_DONE);
  assign cdb_tag          = (r_state == S_DONE) ? r_tag : '0;
  assign cdb_data         = (r_state == S_DONE) ? r_res : '0;
  assign cdb_branch       = 1'b0;
  assign cdb_branch_taken = 1'b0;
endmodule

// File: doc/div_exec_unit.md
DIV_EXEC_UNIT -- requirements
Module: div_exec_unit

Interface
REQ-001 Parameter TAG_WIDTH, default 6: width of rd tag and CDB tag.
REQ-002 Parameter DATA_WIDTH, default 32: operand/result width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 issue_div  input  1  issue unit grants a division this cycle.
REQ-006 div_rs_data  input  32  dividend (rs1 value).
REQ-007 div_rt_data  input  32  divisor (rs2 value).
REQ-008 div_func3  input  3  RISC-V M funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 div_rd_tag  input  TAG_WIDTH  destination tag.
REQ-010 div_exec_ready  output  1  unit idle and able to accept an issue.
REQ-011 cdb_div.cdb_valid  output  1  result valid on CDB_Div.
REQ-012 cdb_div.cdb_tag  output  TAG_WIDTH  tag of the completed result.
REQ-013 cdb_div.cdb_data  output  32  quotient or remainder.
REQ-014 cdb_div.cdb_branch, cdb_div.cdb_branch_taken  output  1 each  tied 0.

Function
REQ-015 FSM states IDLE, BUSY, DONE; div_exec_ready=1 only in IDLE.
REQ-016 Accept: IDLE and issue_div=1 at edge E0 -> latch operands, func3, tag; go to BUSY with iteration counter=0.
REQ-017 issue_div while not IDLE shall be ignored; no operand or tag corruption.
REQ-018 Signed ops (DIV, REM) shall divide absolute values; quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-019 BUSY performs one radix-2 restoring step per cycle on a 33-bit partial remainder; exactly 32 steps.
REQ-020 After step 32 (edge E0+32) sign correction and quotient/remainder select are applied; result registered into DONE at edge E0+33.
REQ-021 cdb_valid=1 for exactly one cycle, between edges E0+33 and E0+34; cdb_tag, cdb_data are stable and valid in that cycle only.
REQ-022 Edge E0+34: DONE -> IDLE; div_exec_ready=1 from then; next accept earliest at edge E0+34.
REQ-023 Latency is fixed at 34 edges regardless of operands, including special cases, so CDB slot reservation stays deterministic.
REQ-024 Divisor zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU result = dividend.
REQ-025 Overflow DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000; REM result 0.
REQ-026 Outside DONE, cdb_valid=0, cdb_tag=0, cdb_data=0.
REQ-027 div_func3[2]=0 codes shall decode by div_func3[1:0] with the same mapping; no error flagged.

Reset
REQ-028 rst=1 at any edge forces IDLE, counter 0, operand/result registers 0, div_exec_ready=1, all cdb_div fields 0.
REQ-029 rst asserted during BUSY or DONE aborts the operation; no cdb_valid pulse for it after rst deasserts.
REQ-030 issue_div sampled in the same edge as rst=1 shall be ignored.

Verification
REQ-031 DIVU 100/7, tag 5 issued at E0 -> cdb_valid only in cycle E0+33..E0+34, tag 5, data 14; REMU same operands -> data 2.
REQ-032 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 123/0 -> 0xFFFFFFFF; REMU 123/0 -> 123; all at latency 34.
REQ-034 Second issue_div pulsed at E0+10 with different operands -> ignored; first result unchanged; ready low until E0+34; back-to-back issue at E0+34 completes at E0+67.
REQ-035 rst pulsed at E0+20 -> ready=1 and cdb fields 0 on following cycle; no cdb_valid in next 40 cycles without new issue.
REQ-036 Random 10k signed/unsigned operand pairs against reference model -> all results and tags match; cdb_valid pulse width always 1.
